// File: rtl/sram_pkg.sv
// sram_pkg: shared types and sizing helpers for the SRAM bank controller.
package sram_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_LATENCY = 1;
    localparam int RSP_FIFO_DEPTH = DEF_RD_LATENCY + 1;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int rsp_fifo_depth(input int lat);
        return lat + 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: synchronous FIFO of any depth (need not be a power of two) with full/empty flags.
module sram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= inc(wp);
            if (do_pop) rp <= inc(rp);
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: single-port SRAM bank with valid/ready requests and in-order buffered responses.
// Define SRAM_INIT_CLEAR_EN to zero the array with a post-reset sweep before accepting traffic.
module sram_bank_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    parameter int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRB_WIDTH-1:0] req_strb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int FD = rsp_fifo_depth(RD_LATENCY);
    localparam int CW = $clog2(FD + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_w_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pipe_v [RD_LATENCY];
    rsp_w_t                pipe_d [RD_LATENCY];
    rsp_w_t                new_rsp, head;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         idx;
    logic                  acc, pop, in_range, fifo_full, fifo_empty;
`ifdef SRAM_INIT_CLEAR_EN
    logic [AW-1:0]         sweep;
`endif

    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = init_done && (cnt < CW'(FD));
    assign idx       = req_addr[AW-1:0];
    assign in_range  = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign new_rsp   = '{rdata: (!req_write && in_range) ? mem[idx] : '0, err: !in_range};
    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = fifo_empty ? '0 : head.rdata;
    assign rsp_err   = fifo_empty ? 1'b0 : head.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) pipe_v[k] <= 1'b0;
            cnt <= '0;
`ifdef SRAM_INIT_CLEAR_EN
            state     <= INIT;
            init_done <= 1'b0;
            sweep     <= '0;
`else
            state     <= RUN;
            init_done <= 1'b1;
`endif
        end else begin
            pipe_v[0] <= acc;
            for (int k = 1; k < RD_LATENCY; k++) pipe_v[k] <= pipe_v[k-1];
            if (acc && !pop) cnt <= cnt + 1'b1;
            else if (pop && !acc) cnt <= cnt - 1'b1;
`ifdef SRAM_INIT_CLEAR_EN
            if (state == INIT) begin
                sweep <= sweep + 1'b1;
                if (sweep == AW'(DEPTH - 1)) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
`else
            init_done <= state == RUN;
`endif
        end
    end

    always_ff @(posedge clk) begin
        pipe_d[0] <= new_rsp;
        for (int k = 1; k < RD_LATENCY; k++) pipe_d[k] <= pipe_d[k-1];
    end

    always_ff @(posedge clk) begin
`ifdef SRAM_INIT_CLEAR_EN
        if (state == INIT) mem[sweep] <= '0;
        else
`endif
        if (acc && req_write && in_range)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (req_strb[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end

    // The outstanding limit guarantees the FIFO always has room for the pipeline's output.
    always_ff @(posedge clk) begin
        if (!rst && pipe_v[RD_LATENCY-1]) assert (!fifo_full || pop);
    end

    sram_rsp_fifo #(.WIDTH($bits(rsp_w_t)), .DEPTH(FD)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_v[RD_LATENCY-1]),
        .din   (pipe_d[RD_LATENCY-1]),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb_sram_bank_ctrl: directed checks of latency, strobes, backpressure, range errors and reset flush.
module tb_sram_bank_ctrl;
    localparam int DW = 32, AW = 8, DEPTH = 200, LAT = 2;
`ifdef SRAM_INIT_CLEAR_EN
    localparam int          INIT_CYC = DEPTH;
    localparam logic        RST_INIT = 1'b0;
    localparam logic [31:0] KEEP     = 32'h0;
`else
    localparam int          INIT_CYC = 0;
    localparam logic        RST_INIT = 1'b1;
    localparam logic [31:0] KEEP     = 32'hDE22BE44;
`endif

    logic          clk = 0, rst = 1;
    logic          req_valid = 0, req_ready, req_write = 0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_strb = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1, rsp_err, init_done;
    logic [DW-1:0] rsp_rdata;
    int            total = 0, bad = 0;
    logic [7:0]    bp_addr [3] = '{8'h10, 8'h20, 8'd199};

    sram_bank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        int n;
        rst = 1;
        tick;
        tick;
        check({tag, "_vld"}, rsp_valid, 0);
        check({tag, "_err"}, rsp_err, 0);
        check({tag, "_rd"}, rsp_rdata, 0);
        check({tag, "_init"}, init_done, RST_INIT);
        rst = 0;
        n = 0;
        while (!init_done && n < 1000) begin
            if (n == 0) check({tag, "_sweep_rdy"}, req_ready, 0);
            tick;
            n++;
        end
        check({tag, "_init_cyc"}, n, INIT_CYC);
    endtask

    task automatic xact(input string tag, input logic w, input logic [7:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] erd, input logic eerr);
        int n;
        check({tag, "_rdy"}, req_ready, 1);
        req_write = w; req_addr = a; req_strb = s; req_wdata = d; req_valid = 1;
        tick;
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, LAT);
        check({tag, "_rd"}, rsp_rdata, erd);
        check({tag, "_err"}, rsp_err, eerr);
        tick;
        check({tag, "_pop"}, rsp_valid, 0);
    endtask

    initial begin
        int n, seen;
        do_reset("rst0");

        xact("wr10", 1, 8'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        xact("rd10", 0, 8'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0);
        xact("wr10s", 1, 8'h10, 4'h5, 32'h11223344, 32'h0, 0);
        xact("rd10s", 0, 8'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);
        xact("wr_zs", 1, 8'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
        xact("rd_zs", 0, 8'h10, 4'h0, 32'h0, 32'hDE22BE44, 0);

        // read-after-write on consecutive cycles
        req_write = 1; req_addr = 8'h20; req_strb = 4'hF; req_wdata = 32'hA5A5A5A5; req_valid = 1;
        tick;
        req_write = 0;
        tick;
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick;
            n++;
        end
        check("raw_wr_lat", n, 1);
        check("raw_wr_rd", rsp_rdata, 0);
        tick;
        check("raw_rd_vld", rsp_valid, 1);
        check("raw_rd_rd", rsp_rdata, 32'hA5A5A5A5);
        tick;

        xact("wr199", 1, 8'd199, 4'hF, 32'h12345678, 32'h0, 0);
        xact("rd200", 0, 8'd200, 4'h0, 32'h0, 32'h0, 1);
        xact("wr255", 1, 8'd255, 4'hF, 32'hCAFEF00D, 32'h0, 1);
        xact("rd199", 0, 8'd199, 4'h0, 32'h0, 32'h12345678, 0);

        // backpressure: three reads fill the outstanding budget
        rsp_ready = 0;
        req_write = 0;
        req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy_pre", req_ready, 1);
            req_addr = bp_addr[i];
            tick;
        end
        req_valid = 0;
        check("bp_rdy_full", req_ready, 0);
        repeat (3) tick;
        check("bp_vld", rsp_valid, 1);
        check("bp_rd0", rsp_rdata, 32'hDE22BE44);
        check("bp_rdy_stall", req_ready, 0);
        tick;
        tick;
        check("bp_stable_vld", rsp_valid, 1);
        check("bp_stable_rd", rsp_rdata, 32'hDE22BE44);
        check("bp_stable_err", rsp_err, 0);
        rsp_ready = 1;
        tick;
        check("bp_rdy_recover", req_ready, 1);
        check("bp_rd1", rsp_rdata, 32'hA5A5A5A5);
        tick;
        check("bp_rd2", rsp_rdata, 32'h12345678);
        tick;
        check("bp_drained", rsp_valid, 0);

        // reset with two reads in flight
        req_write = 0; req_addr = 8'h10; req_valid = 1;
        tick;
        req_addr = 8'h20;
        tick;
        req_valid = 0;
        do_reset("rst_mid");
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            tick;
        end
        check("rst_mid_no_rsp", seen, 0);
        check("rst_mid_rdy", req_ready, 1);
        xact("post_rst", 0, 8'h10, 4'h0, 32'h0, KEEP, 0);

`ifdef SRAM_INIT_CLEAR_EN
        // reset pulse partway through the sweep restarts the full count
        rst = 1;
        tick;
        rst = 0;
        repeat (7) tick;
        check("sweep_mid_init", init_done, 0);
        rst = 1;
        tick;
        rst = 0;
        n = 0;
        while (!init_done && n < 1000) begin
            tick;
            n++;
        end
        check("sweep_restart_cyc", n, DEPTH);
        xact("sweep_rd", 0, 8'd5, 4'h0, 32'h0, 32'h0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Parametrised single-port SRAM bank with a valid/ready request channel and an in-order response channel.
- Adds to the basic SRAM model:
  - configurable read latency
  - depth that need not be a power of two
  - response backpressure via an internal response FIFO
  - out-of-range error reporting
- Sits behind the APB4 bridge or any simple master as the memory-side slave.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in words.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from request accept to response valid; legal range 1..4.
- STRB_WIDTH, DATA_WIDTH/8, derived byte-strobe width; not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_strb  in  STRB_WIDTH  byte enables; writes only.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.
- init_done  out  1  bank ready for traffic.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Outstanding counter = 0; FIFO and latency pipeline flushed.
  - init_done = 1 (feature off).
  - Memory contents are not cleared (feature off).
- Accept and response ordering:
  - A request is accepted when req_valid && req_ready.
  - Every accepted request, read or write, yields exactly one response, in order.
- Write path:
  - Memory is updated at the accept edge.
  - Byte i is written iff req_strb[i]; other bytes keep their value.
  - req_strb = 0 still produces a response.
- Read path:
  - Data is sampled from memory at the accept edge.
  - It passes through a pipeline of RD_LATENCY-1 further stages, then enters the response FIFO.
  - With an empty FIFO and rsp_ready = 1, rsp_valid rises exactly RD_LATENCY cycles after the accept edge.
  - Write responses follow the same latency.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Response FIFO:
  - Depth RD_LATENCY+1.
  - A response pops on rsp_valid && rsp_ready.
  - rsp_* outputs are held stable while rsp_valid && !rsp_ready.
- Outstanding counter:
  - Range 0..RD_LATENCY+1.
  - Increments on accept, decrements on response handshake; unchanged when both occur in the same cycle.
- req_ready rule:
  - req_ready = init_done && (outstanding < RD_LATENCY+1).
  - Driven from registered state only; no combinational path from rsp_ready.
- Out-of-range (req_addr >= DEPTH):
  - No memory access.
  - Response carries rsp_err = 1, rsp_rdata = 0, with normal latency.
- Reset mid-operation:
  - In-flight and buffered responses are discarded; no response is issued for them.
  - Counter returns to 0.
- State machine (2 states):
  - INIT → RUN.
  - Feature off: INIT lasts zero cycles and the block enters RUN on the first cycle after reset.

Optional Feature:
- Macro: SRAM_INIT_CLEAR_EN.
- Defined:
  - On rst deassertion the FSM stays in INIT and a sweep counter writes 0 to addresses 0..DEPTH-1, one per cycle.
  - init_done = 0 and req_ready = 0 during the sweep.
  - init_done rises on the cycle after address DEPTH-1 is written (DEPTH cycles after reset release).
  - rst asserted during the sweep restarts it at address 0.
- Undefined:
  - No sweep logic; init_done is tied high once out of reset.
  - Memory powers up undefined.

Decomposition:
- Package sram_pkg holds:
  - state enum {INIT, RUN}
  - a strobe-width helper function (DATA_WIDTH/8)
  - a response struct {rdata, err}
  - localparam RSP_FIFO_DEPTH = RD_LATENCY+1
- One sub-module: sram_rsp_fifo, a parametrised synchronous FIFO with full/empty flags and the same reset.
- Memory array, latency pipeline, counter and FSM live in sram_bank_ctrl.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF; then read 0x10 (RD_LATENCY = 2) → write response err = 0; read rsp_valid exactly 2 cycles after accept with rdata 0xDEADBEEF.
- Write 0x10, data 0x11223344, strb 0x5 over 0xDEADBEEF → read returns 0xDE22BE44.
- Hold rsp_ready = 0 with RD_LATENCY = 2 and issue reads:
  - req_ready drops after 3 accepts.
  - rsp_* stable while stalled.
  - Releasing rsp_ready drains 3 responses in issue order, and req_ready recovers the cycle after the first pop.
- DEPTH = 200: read addr 200 and write addr 255 → both responses rsp_err = 1, rdata 0; addr 199 is unaffected.
- SRAM_INIT_CLEAR_EN, DEPTH = 16:
  - init_done rises exactly 16 cycles after rst release.
  - req_ready stays 0 until then; any read then returns 0.
  - rst pulse at sweep cycle 7 restarts the full 16-cycle count.
- rst asserted with 2 reads in flight → no rsp_valid after reset; counter 0; the next read completes with normal latency.
